synfifo_rr_drain: RTL
=====================

// Module: synfifo_rr_drain
// PURPOSE
//   Round-robin drain scheduler for N_QUEUE synfifo read ports in the hash-table path.
//   Picks a non-empty FIFO, pulses its rd_en for one cycle and captures the word on
//   the FIFO's registered buf_out one cycle later.
//   Presents the word, tagged with its queue id, on a valid/ready master port.
//   Optional burst mode keeps the grant on one queue for up to BURST consecutive words.
// PARAMETERS
//   N_QUEUE  4  number of FIFOs drained (>=2)
//   D_WIDTH  8  data width of each FIFO and of m_data
//   BURST    4  max consecutive words from one queue before rotating (>=1; 1 = pure RR)
// PORTS
//   clk      in   1                  single clock, all state on posedge
//   rst_n    in   1                  reset, asynchronous, active-low
//   q_empty  in   N_QUEUE            buf_empty of each FIFO
//   q_data   in   N_QUEUE*D_WIDTH    buf_out of each FIFO; queue i at [i*D_WIDTH +: D_WIDTH]
//   q_rd_en  out  N_QUEUE            rd_en to each FIFO; registered, one-hot or zero
//   m_valid  out  1                  output word valid
//   m_ready  in   1                  downstream accepts when m_valid && m_ready
//   m_data   out  D_WIDTH            captured word
//   m_qid    out  clog2(N_QUEUE)     source queue of m_data
//   busy     out  1                  high in any state other than IDLE
// BEHAVIOUR
//   Reset (rst_n low, async): state=IDLE, q_rd_en=0, m_valid=0, m_data=0, m_qid=0,
//     busy=0, grant=0, rr_ptr=0, burst_cnt=0. A word popped but not yet sent is dropped.
//   Arbitration (evaluated in IDLE, and in SEND on the handshake cycle):
//     - stay: grant queue non-empty and burst_cnt<BURST -> same grant, burst_cnt+1
//     - else: first non-empty queue from rr_ptr upward, wrapping N_QUEUE-1 -> 0;
//       grant<=it, burst_cnt<=1, rr_ptr<=grant+1 (mod N_QUEUE)
//     - no queue non-empty -> no grant, go/stay IDLE
//   FSM:
//     IDLE  : grant found -> POP
//     POP   : q_rd_en[grant]=1 for exactly this cycle -> LATCH
//     LATCH : m_data<=q_data[grant], m_qid<=grant, m_valid<=1 -> SEND
//     SEND  : hold m_valid/m_data/m_qid stable while !m_ready.
//             On m_valid&&m_ready: m_valid<=0; arbitrate -> POP if grant found, else IDLE.
//   Latency: IDLE arbitration edge to q_rd_en = 1 cycle; to m_valid = 3 cycles.
//   Throughput: 1 word per 3 cycles with m_ready held high.
//   q_empty is sampled only at arbitration; after POP the FIFO counter has settled by
//     SEND, so a one-entry FIFO is never popped twice.
//   q_rd_en is never asserted for an empty queue or outside POP.
//   Backpressure: no q_rd_en while m_valid && !m_ready.
//   rr_ptr/burst_cnt width: clog2(N_QUEUE) / clog2(BURST+1); wrap is modulo, never
//     exceeds N_QUEUE-1.
//   Simultaneous: a queue going non-empty in the same cycle as arbitration competes
//     only if q_empty is already low at that edge.
// TESTING
//   1 Only q2 holds 0x11,0x22,0x33; m_ready=1, BURST=4 -> three q_rd_en[2] pulses 3 cycles
//     apart; m_data 0x11,0x22,0x33 in order, m_qid=2, then IDLE, busy=0.
//   2 All 4 queues hold 2 words, BURST=1 -> m_qid sequence 0,1,2,3,0,1,2,3.
//   3 All 4 queues hold 2 words, BURST=2 -> m_qid sequence 0,0,1,1,2,2,3,3.
//   4 Word in SEND, m_ready=0 for 10 cycles -> m_valid=1 and m_data/m_qid stable;
//     q_rd_en=0 throughout; the word is accepted on the first m_ready=1 cycle.
//   5 rst_n driven low in LATCH -> q_rd_en=0, m_valid=0, m_data=0, busy=0 immediately,
//     without a clock edge; after release the first grant is queue 0 when it is non-empty.
//   6 Wrap: grant=3, BURST=1, only q0 and q3 non-empty -> next grant 0, rr_ptr=1,
//     never an out-of-range index.

Source files
------------

// File: rtl/synfifo_rr_drain.sv
// synfifo_rr_drain
//   Round-robin drain scheduler for N_QUEUE synfifo read ports. A non-empty FIFO
//   is granted, its rd_en is pulsed for one cycle, the word that appears on the
//   FIFO's registered buf_out is captured on the next cycle and then offered on a
//   valid/ready master port together with the id of the queue it came from.
//   With BURST > 1 the grant may stay on one queue for up to BURST words in a row.
//
// Ports
//   clk      single clock, all state on posedge
//   rst_n    asynchronous active-low reset
//   q_empty  buf_empty of each FIFO
//   q_data   buf_out of each FIFO, queue i at [i*D_WIDTH +: D_WIDTH]
//   q_rd_en  rd_en of each FIFO, registered, one-hot or zero
//   m_valid  output word valid
//   m_ready  downstream accepts when m_valid && m_ready
//   m_data   captured word
//   m_qid    source queue of m_data
//   busy     high whenever the scheduler is not idle
module synfifo_rr_drain #(
  parameter int N_QUEUE = 4,
  parameter int D_WIDTH = 8,
  parameter int BURST   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_QUEUE-1:0]           q_empty,
  input  logic [N_QUEUE*D_WIDTH-1:0]   q_data,
  output logic [N_QUEUE-1:0]           q_rd_en,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [D_WIDTH-1:0]           m_data,
  output logic [$clog2(N_QUEUE)-1:0]   m_qid,
  output logic                         busy
);

  localparam int QW = $clog2(N_QUEUE);
  localparam int BW = $clog2(BURST + 1);
  localparam logic [QW-1:0] LAST_Q    = QW'(N_QUEUE - 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(BURST);

  typedef enum logic [1:0] {
    IDLE,
    POP,
    LATCH,
    SEND
  } state_t;

  state_t           state, state_next;
  logic [QW-1:0]    grant, rr_ptr;
  logic [BW-1:0]    burst_cnt;

  logic             arb_found;
  logic [QW-1:0]    arb_grant, arb_ptr, cand;
  logic [BW-1:0]    arb_cnt;
  logic             do_arb;
  logic [D_WIDTH-1:0] sel_data;

  // Modulo-N_QUEUE increment; works for non-power-of-two queue counts too.
  function automatic logic [QW-1:0] next_q(input logic [QW-1:0] q);
    return (q == LAST_Q) ? '0 : q + 1'b1;
  endfunction

  // Arbitration result, consumed only when the FSM says an arbitration happens.
  // rr_ptr always tracks the queue after the current grant, including when the
  // grant is kept for a burst, so the search after a burst starts past it.
  always_comb begin
    arb_found = 1'b0;
    arb_grant = grant;
    arb_cnt   = burst_cnt;
    arb_ptr   = rr_ptr;
    cand      = rr_ptr;
    if (!q_empty[grant] && (burst_cnt < BURST_MAX)) begin
      arb_found = 1'b1;
      arb_cnt   = burst_cnt + 1'b1;
      arb_ptr   = next_q(grant);
    end else begin
      for (int k = 0; k < N_QUEUE; k++) begin
        if (!arb_found && !q_empty[cand]) begin
          arb_found = 1'b1;
          arb_grant = cand;
          arb_cnt   = BW'(1);
          arb_ptr   = next_q(cand);
        end
        cand = next_q(cand);
      end
    end
  end

  // Next-state logic. Arbitration happens in IDLE and on the SEND handshake only,
  // so q_rd_en can never fire while a word is waiting for m_ready.
  always_comb begin
    state_next = state;
    do_arb     = 1'b0;
    case (state)
      IDLE: begin
        do_arb = 1'b1;
        if (arb_found) state_next = POP;
      end
      POP:   state_next = LATCH;
      LATCH: state_next = SEND;
      SEND: begin
        if (m_valid && m_ready) begin
          do_arb     = 1'b1;
          state_next = arb_found ? POP : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sel_data = q_data[int'(grant)*D_WIDTH +: D_WIDTH];
  end

  // State, grant bookkeeping and output registers. q_rd_en is loaded on the edge
  // that enters POP, so it is high for exactly the POP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      q_rd_en   <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_qid     <= '0;
    end else begin
      state   <= state_next;
      q_rd_en <= '0;
      if (do_arb && arb_found) begin
        grant     <= arb_grant;
        burst_cnt <= arb_cnt;
        rr_ptr    <= arb_ptr;
        q_rd_en   <= {{(N_QUEUE-1){1'b0}}, 1'b1} << arb_grant;
      end
      if (state == LATCH) begin
        m_data  <= sel_data;
        m_qid   <= grant;
        m_valid <= 1'b1;
      end else if ((state == SEND) && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
